mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Round-robin arbiter that shares the single-outstanding memory latency injector between NUM_REQ requesters (DMA, weight fetch, activation fetch, host). It grants one requester, forwards that request's is_dram/size fields to the injector, holds the grant until the injector responds, and routes the response back as a one-hot pulse to the owning requester. It sits between the requester ports and `memory_latency_injector`. At most one transaction is in flight.

## Interface
- NUM_REQ, 4: number of requesters, 2..8; ID_W = max(1, $clog2(NUM_REQ)).
- SIZE_W, 16: request/response size width in bytes.
- TIMEOUT_CYCLES, 1024: WAIT-state watchdog limit; used only with MEM_ARB_TIMEOUT_EN.

- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-low.
- rq_valid  in  NUM_REQ  per-requester request valid.
- rq_is_dram  in  NUM_REQ  per-requester DRAM (1) / SRAM (0) select.
- rq_size_bytes  in  NUM_REQ*SIZE_W  requester i at [i*SIZE_W +: SIZE_W].
- rq_ready  out  NUM_REQ  combinational, one-hot or zero; handshake = rq_valid[i] & rq_ready[i].
- rs_valid  out  NUM_REQ  registered one-cycle one-hot response pulse.
- rs_size_bytes  out  SIZE_W  response size, valid with rs_valid.
- rs_error  out  1  response is a timeout error, valid with rs_valid.
- mem_req_valid  out  1  to injector req_valid.
- mem_req_is_dram  out  1  to injector req_is_dram.
- mem_req_size_bytes  out  SIZE_W  to injector req_size_bytes.
- mem_req_ready  in  1  from injector req_ready.
- mem_resp_valid  in  1  from injector resp_valid.
- mem_resp_size_bytes  in  SIZE_W  from injector resp_size_bytes.
- grant_id  out  ID_W  id of current or last owner.
- busy  out  1  state != IDLE.
- grant_count  out  32  total grants, wraps at 2^32.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: winner = first i with rq_valid[i], searching ptr+1 .. ptr+NUM_REQ modulo NUM_REQ. rq_ready[winner] = 1; all other bits are 0. On handshake: latch id/is_dram/size, ptr <= id, grant_id <= id, grant_count++, go ISSUE. With no rq_valid: stay IDLE, rq_ready = 0.
- ISSUE: mem_req_valid = 1 with latched fields, held stable. When mem_req_ready = 1 at posedge, go WAIT. No cycle limit in ISSUE.
- WAIT: mem_req_valid = 0. When mem_resp_valid = 1: rs_valid[id] <= 1, rs_size_bytes <= mem_resp_size_bytes, rs_error <= 0, go IDLE.
- mem_resp_valid in IDLE or ISSUE is ignored; it causes no pulse and no state change.
- rq_ready is 0 in ISSUE and WAIT. Requesters hold rq_valid until handshake.
- Reset (reset = 0 at posedge), including mid-transaction: state IDLE, ptr = NUM_REQ-1 (requester 0 wins first), rs_valid = 0, rs_size_bytes = 0, rs_error = 0, grant_id = 0, grant_count = 0, timeout counter = 0, latched fields = 0. Combinational outputs are therefore mem_req_valid = 0, busy = 0, rq_ready = 0 while reset is low. Any in-flight transaction is dropped with no response.

## Timing
- Handshake at cycle T: mem_req_valid high from T+1.
- Injector accepts at cycle A: WAIT from A+1.
- mem_resp_valid at cycle R: rs_valid pulse at R+1. IDLE at R+1, so a new handshake can occur at R+1. Back-to-back grant gap is one cycle after the response.
- The rs_valid pulse and a new rq_ready can coexist in the same cycle.
- grant_count updates at T+1.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: a 32-bit counter clears on WAIT entry and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES with mem_resp_valid = 0, then next cycle rs_valid[id] = 1, rs_error = 1, rs_size_bytes = 0, and the state goes to IDLE. If mem_resp_valid = 1 in the expiry cycle, the normal response wins. A late response arriving after timeout follows the IDLE/ISSUE ignore rule. If a new transaction has already reached WAIT, the late response is attributed to it; recovery requires resetting the injector.
- Undefined: no counter, WAIT waits indefinitely, rs_error is constant 0.

## Test plan
- Reset held 5 cycles with rq_valid = 4'b1111 -> rq_ready = 0, mem_req_valid = 0, busy = 0, grant_count = 0. After release, requester 0 is granted first.
- Requester 2 alone, SRAM, size 32; injector latency 2 -> one mem_req_valid handshake with size 32 and is_dram 0. rs_valid = 4'b0100 for one cycle with rs_size_bytes = 32. grant_count = 1.
- rq_valid = 4'b1111 held, 8 transactions -> grant order 0,1,2,3,0,1,2,3. Each rs_valid matches its grant_id. grant_count = 8.
- Requester 1 DRAM size 64, mem_req_ready held low 6 cycles -> mem_req_valid and fields stable throughout. WAIT entered the cycle after ready rises.
- Reset pulsed during WAIT, then mem_resp_valid arrives while IDLE -> no rs_valid pulse, state IDLE, ptr back to NUM_REQ-1.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, injector never responds -> rs_valid[id] with rs_error = 1 and rs_size_bytes = 0 exactly 17 cycles after WAIT entry. The arbiter then grants the next requester.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory latency injector among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SIZE_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        rq_valid,
  input  logic [NUM_REQ-1:0]        rq_is_dram,
  input  logic [NUM_REQ*SIZE_W-1:0] rq_size_bytes,
  output logic [NUM_REQ-1:0]        rq_ready,
  output logic [NUM_REQ-1:0]        rs_valid,
  output logic [SIZE_W-1:0]         rs_size_bytes,
  output logic                      rs_error,
  output logic                      mem_req_valid,
  output logic                      mem_req_is_dram,
  output logic [SIZE_W-1:0]         mem_req_size_bytes,
  input  logic                      mem_req_ready,
  input  logic                      mem_resp_valid,
  input  logic [SIZE_W-1:0]         mem_resp_size_bytes,
  output logic [((NUM_REQ > 2) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                      busy,
  output logic [31:0]               grant_count
);
  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                is_dram_q, is_dram_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [31:0]         grant_count_q, grant_count_d;
  logic [NUM_REQ-1:0]  rs_valid_q, rs_valid_d;
  logic [SIZE_W-1:0]   rs_size_q, rs_size_d;
  logic                rs_error_q, rs_error_d;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [31:0]         tmo_cnt_q, tmo_cnt_d;
`else
  logic                unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES > 0);
`endif

  logic                win_found_s;
  logic [ID_W-1:0]     win_id_s;
  int                  idx_s;
  logic                handshake_s;

  // Search ptr+1 .. ptr+NUM_REQ so the last owner has lowest priority next time.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    idx_s       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found_s && rq_valid[idx_s]) begin
        win_found_s = 1'b1;
        win_id_s    = ID_W'(idx_s);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  always_comb begin
    rq_ready = '0;
    if (reset && (state_q == S_IDLE) && win_found_s) begin
      rq_ready[win_id_s] = 1'b1;
    end else begin
      rq_ready = '0;
    end
  end

  assign handshake_s = |(rq_valid & rq_ready);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    is_dram_d     = is_dram_q;
    size_d        = size_q;
    grant_id_d    = grant_id_q;
    grant_count_d = grant_count_q;
    rs_valid_d    = '0;
    rs_size_d     = rs_size_q;
    rs_error_d    = rs_error_q;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (handshake_s) begin
          id_d          = win_id_s;
          is_dram_d     = rq_is_dram[win_id_s];
          size_d        = rq_size_bytes[win_id_s*SIZE_W +: SIZE_W];
          ptr_d         = win_id_s;
          grant_id_d    = win_id_s;
          grant_count_d = grant_count_q + 32'd1;
          state_d       = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_cnt_d = 32'd0;
`endif
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          rs_valid_d[id_q] = 1'b1;
          rs_size_d        = mem_resp_size_bytes;
          rs_error_d       = 1'b0;
          state_d          = S_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (tmo_cnt_q >= 32'(TIMEOUT_CYCLES)) begin
          rs_valid_d[id_q] = 1'b1;
          rs_size_d        = '0;
          rs_error_d       = 1'b1;
          state_d          = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
`else
        end else begin
          state_d = S_WAIT;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Synchronous active-low reset drops any in-flight transaction without a response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= ID_W'(NUM_REQ - 1);
      id_q          <= '0;
      is_dram_q     <= 1'b0;
      size_q        <= '0;
      grant_id_q    <= '0;
      grant_count_q <= 32'd0;
      rs_valid_q    <= '0;
      rs_size_q     <= '0;
      rs_error_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_q     <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      is_dram_q     <= is_dram_d;
      size_q        <= size_d;
      grant_id_q    <= grant_id_d;
      grant_count_q <= grant_count_d;
      rs_valid_q    <= rs_valid_d;
      rs_size_q     <= rs_size_d;
      rs_error_q    <= rs_error_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign mem_req_valid      = reset && (state_q == S_ISSUE);
  assign mem_req_is_dram    = is_dram_q;
  assign mem_req_size_bytes = size_q;
  assign busy               = reset && (state_q != S_IDLE);
  assign grant_id           = grant_id_q;
  assign grant_count        = grant_count_q;
  assign rs_valid           = rs_valid_q;
  assign rs_size_bytes      = rs_size_q;
  assign rs_error           = rs_error_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter; drives on and samples at the negative clock edge.
module tb_mem_req_arbiter;
  logic        clk;
  logic        reset;
  logic [3:0]  rq_valid;
  logic [3:0]  rq_is_dram;
  logic [63:0] rq_size_bytes;
  logic [3:0]  rq_ready;
  logic [3:0]  rs_valid;
  logic [15:0] rs_size_bytes;
  logic        rs_error;
  logic        mem_req_valid;
  logic        mem_req_is_dram;
  logic [15:0] mem_req_size_bytes;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_size_bytes;
  logic [1:0]  grant_id;
  logic        busy;
  logic [31:0] grant_count;

  int vecs = 0;
  int errs = 0;

  mem_req_arbiter #(.NUM_REQ(4), .SIZE_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .rq_valid(rq_valid), .rq_is_dram(rq_is_dram), .rq_size_bytes(rq_size_bytes),
    .rq_ready(rq_ready), .rs_valid(rs_valid), .rs_size_bytes(rs_size_bytes),
    .rs_error(rs_error), .mem_req_valid(mem_req_valid), .mem_req_is_dram(mem_req_is_dram),
    .mem_req_size_bytes(mem_req_size_bytes), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_size_bytes(mem_resp_size_bytes),
    .grant_id(grant_id), .busy(busy), .grant_count(grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rq_valid = 4'b1111;
    rq_is_dram = 4'b0000;
    rq_size_bytes = {16'd40, 16'd30, 16'd20, 16'd10};
    repeat (5) @(negedge clk);
    vecs++; if (rq_ready !== 4'b0000) begin errs++; $display("FAIL reset_rq_ready: got %b expected 0000", rq_ready); end
    vecs++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vecs++; if (grant_count !== 32'd0) begin errs++; $display("FAIL reset_grant_count: got %0d expected 0", grant_count); end
    vecs++; if (rs_valid !== 4'b0000) begin errs++; $display("FAIL reset_rs_valid: got %b expected 0000", rs_valid); end
    reset = 1'b1;
    #1;
    vecs++; if (rq_ready !== 4'b0001) begin errs++; $display("FAIL reset_first_ready: got %b expected 0001", rq_ready); end
    @(negedge clk);
    rq_valid = 4'b0000;
    vecs++; if (grant_id !== 2'd0) begin errs++; $display("FAIL reset_first_grant: got %0d expected 0", grant_id); end
    vecs++; if (mem_req_size_bytes !== 16'd10) begin errs++; $display("FAIL reset_first_size: got %0d expected 10", mem_req_size_bytes); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_size_bytes = 16'd10;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    vecs++; if (rs_valid !== 4'b0001) begin errs++; $display("FAIL reset_first_resp: got %b expected 0001", rs_valid); end
  endtask

  task automatic test_single();
    do_reset(2);
    rq_valid = 4'b0100;
    rq_is_dram = 4'b0000;
    rq_size_bytes = {16'd0, 16'd32, 16'd0, 16'd0};
    #1;
    vecs++; if (rq_ready !== 4'b0100) begin errs++; $display("FAIL single_ready: got %b expected 0100", rq_ready); end
    @(negedge clk);
    rq_valid = 4'b0000;
    vecs++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL single_req_valid: got %b expected 1", mem_req_valid); end
    vecs++; if (mem_req_size_bytes !== 16'd32) begin errs++; $display("FAIL single_req_size: got %0d expected 32", mem_req_size_bytes); end
    vecs++; if (mem_req_is_dram !== 1'b0) begin errs++; $display("FAIL single_req_dram: got %b expected 0", mem_req_is_dram); end
    vecs++; if (grant_count !== 32'd1) begin errs++; $display("FAIL single_grant_count: got %0d expected 1", grant_count); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    vecs++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL single_wait_req_valid: got %b expected 0", mem_req_valid); end
    @(negedge clk);
    vecs++; if (rs_valid !== 4'b0000) begin errs++; $display("FAIL single_early_rs: got %b expected 0000", rs_valid); end
    mem_resp_valid = 1'b1;
    mem_resp_size_bytes = 16'd32;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    vecs++; if (rs_valid !== 4'b0100) begin errs++; $display("FAIL single_rs_valid: got %b expected 0100", rs_valid); end
    vecs++; if (rs_size_bytes !== 16'd32) begin errs++; $display("FAIL single_rs_size: got %0d expected 32", rs_size_bytes); end
    vecs++; if (rs_error !== 1'b0) begin errs++; $display("FAIL single_rs_error: got %b expected 0", rs_error); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle: got %b expected 0", busy); end
    @(negedge clk);
    vecs++; if (rs_valid !== 4'b0000) begin errs++; $display("FAIL single_pulse_width: got %b expected 0000", rs_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    do_reset(2);
    rq_valid = 4'b1111;
    rq_is_dram = 4'b1010;
    rq_size_bytes = {16'd4, 16'd3, 16'd2, 16'd1};
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_id = 2'(k % 4);
      vecs++; if (rq_ready !== (4'b0001 << exp_id)) begin errs++; $display("FAIL rr_ready_%0d: got %b expected %b", k, rq_ready, 4'b0001 << exp_id); end
      @(negedge clk);
      vecs++; if (grant_id !== exp_id) begin errs++; $display("FAIL rr_grant_%0d: got %0d expected %0d", k, grant_id, exp_id); end
      vecs++; if (rq_ready !== 4'b0000) begin errs++; $display("FAIL rr_issue_ready_%0d: got %b expected 0000", k, rq_ready); end
      vecs++; if (mem_req_size_bytes !== 16'(exp_id + 2'd1)) begin errs++; $display("FAIL rr_size_%0d: got %0d expected %0d", k, mem_req_size_bytes, exp_id + 1); end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_size_bytes = 16'(16 * (k + 1));
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (k == 7) rq_valid = 4'b0000;
      vecs++; if (rs_valid !== (4'b0001 << exp_id)) begin errs++; $display("FAIL rr_rs_%0d: got %b expected %b", k, rs_valid, 4'b0001 << exp_id); end
      vecs++; if (rs_size_bytes !== 16'(16 * (k + 1))) begin errs++; $display("FAIL rr_rs_size_%0d: got %0d expected %0d", k, rs_size_bytes, 16 * (k + 1)); end
    end
    vecs++; if (grant_count !== 32'd8) begin errs++; $display("FAIL rr_grant_count: got %0d expected 8", grant_count); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rq_valid = 4'b0010;
    rq_is_dram = 4'b0010;
    rq_size_bytes = {16'd0, 16'd0, 16'd64, 16'd0};
    #1;
    vecs++; if (rq_ready !== 4'b0010) begin errs++; $display("FAIL bp_ready: got %b expected 0010", rq_ready); end
    @(negedge clk);
    rq_valid = 4'b0000;
    rq_is_dram = 4'b0000;
    rq_size_bytes = {16'd0, 16'd0, 16'd99, 16'd0};
    for (int c = 0; c < 6; c++) begin
      vecs++; if ({mem_req_valid, mem_req_is_dram, mem_req_size_bytes} !== {1'b1, 1'b1, 16'd64})
        begin errs++; $display("FAIL bp_stable_%0d: got v=%b d=%b s=%0d expected v=1 d=1 s=64", c, mem_req_valid, mem_req_is_dram, mem_req_size_bytes); end
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    vecs++; if ({mem_req_valid, busy} !== 2'b01) begin errs++; $display("FAIL bp_wait_entry: got v=%b busy=%b expected v=0 busy=1", mem_req_valid, busy); end
    mem_resp_valid = 1'b1;
    mem_resp_size_bytes = 16'd64;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    vecs++; if (rs_valid !== 4'b0010) begin errs++; $display("FAIL bp_rs: got %b expected 0010", rs_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    rq_valid = 4'b0001;
    @(negedge clk);
    rq_valid = 4'b0000;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    vecs++; if ({busy, mem_req_valid} !== 2'b00) begin errs++; $display("FAIL rw_reset_idle: got busy=%b v=%b expected 0 0", busy, mem_req_valid); end
    vecs++; if (grant_count !== 32'd0) begin errs++; $display("FAIL rw_grant_count: got %0d expected 0", grant_count); end
    reset = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_size_bytes = 16'd77;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    vecs++; if (rs_valid !== 4'b0000) begin errs++; $display("FAIL rw_late_resp: got %b expected 0000", rs_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rw_state: got busy=%b expected 0", busy); end
    rq_valid = 4'b1111;
    #1;
    vecs++; if (rq_ready !== 4'b0001) begin errs++; $display("FAIL rw_ptr: got %b expected 0001", rq_ready); end
    rq_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_wait_limit();
    rq_valid = 4'b1000;
    rq_size_bytes = {16'd8, 16'd0, 16'd0, 16'd0};
    @(negedge clk);
    rq_valid = 4'b0000;
    vecs++; if (grant_id !== 2'd3) begin errs++; $display("FAIL wl_grant: got %0d expected 3", grant_id); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      vecs++; if (rs_valid !== 4'b0000) begin errs++; $display("FAIL tmo_early_%0d: got %b expected 0000", c, rs_valid); end
    end
    rq_valid = 4'b0001;
    @(negedge clk);
    vecs++; if (rs_valid !== 4'b1000) begin errs++; $display("FAIL tmo_rs: got %b expected 1000", rs_valid); end
    vecs++; if (rs_error !== 1'b1) begin errs++; $display("FAIL tmo_error: got %b expected 1", rs_error); end
    vecs++; if (rs_size_bytes !== 16'd0) begin errs++; $display("FAIL tmo_size: got %0d expected 0", rs_size_bytes); end
    vecs++; if (rq_ready !== 4'b0001) begin errs++; $display("FAIL tmo_next_ready: got %b expected 0001", rq_ready); end
    @(negedge clk);
    rq_valid = 4'b0000;
    vecs++; if (grant_id !== 2'd0) begin errs++; $display("FAIL tmo_next_grant: got %0d expected 0", grant_id); end
`else
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c % 10 == 0) begin
        vecs++; if ({busy, rs_valid} !== 5'b10000) begin errs++; $display("FAIL nowdt_wait_%0d: got busy=%b rs=%b expected 1 0000", c, busy, rs_valid); end
      end
    end
    mem_resp_valid = 1'b1;
    mem_resp_size_bytes = 16'd8;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    vecs++; if ({rs_valid, rs_error} !== 5'b10000) begin errs++; $display("FAIL nowdt_resp: got rs=%b err=%b expected 1000 0", rs_valid, rs_error); end
`endif
  endtask

  initial begin
    reset = 1'b0;
    rq_valid = 4'b0000;
    rq_is_dram = 4'b0000;
    rq_size_bytes = 64'd0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_size_bytes = 16'd0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_in_wait();
    test_wait_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
